// File: rtl/uart_tx_burst.sv
// RS-485 burst UART transmitter: reads BYTES words from a memory page
// and serialises them with configurable framing and direction timing.
`timescale 1ns/1ps
module uart_tx_burst #(
  parameter int DATA_BITS   = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int BYTES       = 4,
  parameter int ADDR_W      = 9,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int GAP_BITS    = 1,
  parameter int DIR_ON_DLY  = 15,
  parameter int TX_LEAD     = 15,
  parameter int DIR_OFF_DLY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RQ,
  input  logic [5:0]           cycle,
  input  logic [DATA_BITS-1:0] data,
  output logic [ADDR_W-1:0]    addr,
  output logic                 tx,
  output logic                 dirTX,
  output logic                 dirRX,
  output logic                 full,
  output logic                 busy,
  output logic [7:0]           idx
);

  typedef enum logic [3:0] {
    IDLE, DIRON, START, DATA, PAR,
    STOP, GAP, DIROFF, DONE
  } state_t;

  localparam logic [15:0] ON_T   = 16'(DIR_ON_DLY - 1);
  localparam logic [15:0] LEAD_T = 16'(DIR_ON_DLY + TX_LEAD - 1);
  localparam logic [15:0] OFF_T  = 16'(DIR_OFF_DLY - 1);
  localparam logic [15:0] BIT_T  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] DBIT_T = 16'(DATA_BITS - 1);
  localparam logic [15:0] STOP_T = 16'(STOP_BITS - 1);
  localparam logic [15:0] GAP_T  = 16'(GAP_BITS - 1);
  localparam logic [7:0]  LAST   = 8'(BYTES);

  state_t state, state_d;
  logic rq_m, rq_s;
  logic [15:0] cnt, cnt_d;
  logic [15:0] bcnt, bcnt_d;
  logic [15:0] bit_i, bit_d;
  logic [DATA_BITS-1:0] sh, sh_d;
  logic par, par_d;
  logic [7:0] idx_d;
  logic [5:0] cyc, cyc_d;
  logic tx_d, dirTX_d, dirRX_d;
  logic full_d, busy_d;
  logic wrap, pbit;

  assign wrap = (bcnt == BIT_T);
  assign pbit = (PARITY == 2) ? ~(^data) : ^data;

  // modular arithmetic: truncating operands first gives the same low bits
  assign addr = ADDR_W'(cyc) * ADDR_W'(BYTES)
              + ADDR_W'(idx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rq_m  <= 1'b0;
      rq_s  <= 1'b0;
      cnt   <= '0;
      bcnt  <= '0;
      bit_i <= '0;
      sh    <= '0;
      par   <= 1'b0;
      idx   <= '0;
      cyc   <= '0;
      tx    <= 1'b1;
      dirTX <= 1'b0;
      dirRX <= 1'b0;
      full  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      rq_m  <= RQ;
      rq_s  <= rq_m;
      cnt   <= cnt_d;
      bcnt  <= bcnt_d;
      bit_i <= bit_d;
      sh    <= sh_d;
      par   <= par_d;
      idx   <= idx_d;
      cyc   <= cyc_d;
      tx    <= tx_d;
      dirTX <= dirTX_d;
      dirRX <= dirRX_d;
      full  <= full_d;
      busy  <= busy_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bcnt_d  = '0;
    bit_d   = bit_i;
    sh_d    = sh;
    par_d   = par;
    idx_d   = idx;
    cyc_d   = cyc;
    tx_d    = tx;
    dirTX_d = dirTX;
    dirRX_d = dirRX;
    full_d  = full;
    busy_d  = busy;
    unique case (state)
      IDLE: begin
        if (rq_s) begin
          state_d = DIRON;
          busy_d  = 1'b1;
          idx_d   = '0;
          dirRX_d = 1'b1;
          cnt_d   = '0;
          cyc_d   = cycle;
        end
      end
      DIRON: begin
        cnt_d = cnt + 16'd1;
        if (cnt == ON_T) dirTX_d = 1'b1;
        if (cnt == LEAD_T) begin
          state_d = START;
          tx_d    = 1'b0;
          sh_d    = data;
          par_d   = pbit;
        end
      end
      START: begin
        bcnt_d = wrap ? 16'd0 : bcnt + 16'd1;
        if (wrap) begin
          state_d = DATA;
          tx_d    = sh[0];
          sh_d    = sh >> 1;
          bit_d   = '0;
        end
      end
      DATA: begin
        bcnt_d = wrap ? 16'd0 : bcnt + 16'd1;
        if (wrap) begin
          if (bit_i != DBIT_T) begin
            bit_d = bit_i + 16'd1;
            tx_d  = sh[0];
            sh_d  = sh >> 1;
          end else if (PARITY != 0) begin
            state_d = PAR;
            tx_d    = par;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
            idx_d   = idx + 8'd1;
            bit_d   = '0;
          end
        end
      end
      PAR: begin
        bcnt_d = wrap ? 16'd0 : bcnt + 16'd1;
        if (wrap) begin
          state_d = STOP;
          tx_d    = 1'b1;
          idx_d   = idx + 8'd1;
          bit_d   = '0;
        end
      end
      STOP: begin
        bcnt_d = wrap ? 16'd0 : bcnt + 16'd1;
        if (wrap) begin
          if (bit_i == STOP_T) begin
            state_d = GAP;
            bit_d   = '0;
          end else begin
            bit_d = bit_i + 16'd1;
          end
        end
      end
      GAP: begin
        bcnt_d = wrap ? 16'd0 : bcnt + 16'd1;
        if (wrap) begin
          if (bit_i != GAP_T) begin
            bit_d = bit_i + 16'd1;
          end else if (idx == LAST) begin
            state_d = DIROFF;
            dirTX_d = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = START;
            tx_d    = 1'b0;
            sh_d    = data;
            par_d   = pbit;
          end
        end
      end
      DIROFF: begin
        cnt_d = cnt + 16'd1;
        if (cnt == OFF_T) begin
          state_d = DONE;
          dirRX_d = 1'b0;
          full_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      DONE: begin
        if (!rq_s) begin
          state_d = IDLE;
          full_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_burst.sv
// Directed bench for uart_tx_burst: default framing, even/odd parity,
// slow baud, RQ drop, mid-burst reset and address wrap.
`timescale 1ns/1ps
module tb_uart_tx_burst;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // u0: defaults, memory[addr] = addr[7:0]
  logic r0;
  logic [5:0] cy0;
  logic [7:0] dat0;
  logic [8:0] a0;
  logic tx0, dt0, dr0, f0, b0;
  logic [7:0] i0;

  always_ff @(posedge clk) dat0 <= 8'(a0);

  uart_tx_burst u0 (
    .clk(clk), .reset(rst_n), .RQ(r0), .cycle(cy0),
    .data(dat0), .addr(a0), .tx(tx0), .dirTX(dt0),
    .dirRX(dr0), .full(f0), .busy(b0), .idx(i0)
  );

  // u1: 7E2, 4 clocks per bit
  logic r1;
  logic [5:0] cy1;
  logic [6:0] dat1;
  logic [8:0] a1;
  logic tx1, dt1, dr1, f1, b1;
  logic [7:0] i1;

  uart_tx_burst #(
    .DATA_BITS(7), .CLKS_PER_BIT(4), .BYTES(1),
    .PARITY(1), .STOP_BITS(2), .DIR_ON_DLY(2),
    .TX_LEAD(2), .DIR_OFF_DLY(2)
  ) u1 (
    .clk(clk), .reset(rst_n), .RQ(r1), .cycle(cy1),
    .data(dat1), .addr(a1), .tx(tx1), .dirTX(dt1),
    .dirRX(dr1), .full(f1), .busy(b1), .idx(i1)
  );

  // u2: 8O1, one frame, 6-bit address
  logic r2;
  logic [5:0] cy2;
  logic [7:0] dat2;
  logic [5:0] a2;
  logic tx2, dt2, dr2, f2, b2;
  logic [7:0] i2;

  uart_tx_burst #(
    .BYTES(1), .ADDR_W(6), .PARITY(2),
    .DIR_ON_DLY(2), .TX_LEAD(2), .DIR_OFF_DLY(2)
  ) u2 (
    .clk(clk), .reset(rst_n), .RQ(r2), .cycle(cy2),
    .data(dat2), .addr(a2), .tx(tx2), .dirTX(dt2),
    .dirRX(dr2), .full(f2), .busy(b2), .idx(i2)
  );

  task automatic burst2(input logic [7:0] d,
                        input logic [11:0] pat);
    int n;
    logic [11:0] obs;
    dat2 = d;
    r2 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (tx2 && n < 40);
    chk("p2_start", {63'd0, tx2}, 64'd0);
    chk("p2_addr", 64'(a2), 64'd63);
    obs = '0;
    obs[0] = tx2;
    for (int k = 1; k < 12; k++) begin
      @(posedge clk); #1;
      obs[k] = tx2;
    end
    chk("p2_frame", 64'(obs), 64'(pat));
    @(posedge clk); #1;
    chk("p2_end", {63'd0, dt2}, 64'd0);
    r2 = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("p2_idle", {63'd0, b2}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] v;
    logic [47:0] obs48, exp48;
    logic [11:0] pat1;

    rst_n = 1'b0;
    r0 = 0; r1 = 0; r2 = 0;
    cy0 = 0; cy1 = 0; cy2 = 6'd63;
    dat1 = 7'h55; dat2 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {63'd0, tx0}, 64'd1);
    chk("rst_dirTX", {63'd0, dt0}, 64'd0);
    chk("rst_dirRX", {63'd0, dr0}, 64'd0);
    chk("rst_full", {63'd0, f0}, 64'd0);
    chk("rst_busy", {63'd0, b0}, 64'd0);
    chk("rst_idx", 64'(i0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // default burst, page 3
    cy0 = 6'd3;
    r0 = 1'b1;
    @(posedge clk);
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (!dr0 && n < 20);
    chk("dirRX_lat", 64'(n), 64'd2);
    chk("busy_on", {63'd0, b0}, 64'd1);
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (!dt0 && n < 40);
    chk("dirTX_lat", 64'(n), 64'd15);
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (tx0 && n < 40);
    chk("tx_lead", 64'(n), 64'd15);

    for (int f = 0; f < 4; f++) begin
      chk("addr", 64'(a0), 64'(12 + f));
      v = '0;
      for (int b = 0; b < 8; b++) begin
        @(posedge clk); #1;
        v[b] = tx0;
      end
      chk("byte", 64'(v), 64'(12 + f));
      @(posedge clk); #1;
      chk("stop", {63'd0, tx0}, 64'd1);
      chk("idx", 64'(i0), 64'(f + 1));
      @(posedge clk); #1;
      chk("gap", {63'd0, tx0}, 64'd1);
      @(posedge clk); #1;
      if (f < 3) chk("next_start", {63'd0, tx0}, 64'd0);
      else chk("dirTX_off", {63'd0, dt0}, 64'd0);
    end
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (!f0 && n < 20);
    chk("full_lat", 64'(n), 64'd4);
    chk("busy_done", {63'd0, b0}, 64'd0);
    chk("dirRX_off", {63'd0, dr0}, 64'd0);

    // RQ held high: stays in DONE, no retrigger
    repeat (20) @(posedge clk);
    #1;
    chk("hold_full", {63'd0, f0}, 64'd1);
    chk("no_retrig", {63'd0, b0}, 64'd0);
    r0 = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (f0 && n < 10);
    chk("full_clr", 64'(n), 64'd3);

    // RQ dropped during frame 1: burst still completes
    r0 = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (!b0 && n < 10);
    chk("drop_busy", 64'(n), 64'd3);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (i0 == 8'd1) r0 = 1'b0;
    end while (!f0 && n < 200);
    chk("drop_len", 64'(n), 64'd78);
    chk("drop_idx", 64'(i0), 64'd4);
    @(posedge clk); #1;
    chk("full_pulse", {63'd0, f0}, 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("drop_idle", {63'd0, b0}, 64'd0);

    // 7E2 at 4 clocks per bit, data 0x55
    pat1 = 12'hEAA;
    for (int k = 0; k < 48; k++) exp48[k] = pat1[k / 4];
    r1 = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (tx1 && n < 60);
    obs48 = '0;
    obs48[0] = tx1;
    for (int k = 1; k < 48; k++) begin
      @(posedge clk); #1;
      obs48[k] = tx1;
    end
    chk("p1_frame", 64'(obs48), 64'(exp48));
    chk("p1_par", 64'(obs48[35:32]), 64'd0);
    chk("p1_dt_hold", {63'd0, dt1}, 64'd1);
    @(posedge clk); #1;
    chk("p1_len", {63'd0, dt1}, 64'd0);
    r1 = 1'b0;

    // 8O1, page 63 wraps to address 63
    burst2(8'h01, 12'hC02);
    burst2(8'h03, 12'hE06);

    // reset during the first data bit of a burst
    r0 = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (tx0 && n < 60);
    @(posedge clk); #1;
    chk("pre_rst_tx", {63'd0, tx0}, 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", {63'd0, tx0}, 64'd1);
    chk("mid_rst_dirTX", {63'd0, dt0}, 64'd0);
    chk("mid_rst_dirRX", {63'd0, dr0}, 64'd0);
    chk("mid_rst_busy", {63'd0, b0}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (!dr0 && n < 10);
    chk("restart_lat", 64'(n), 64'd3);
    chk("restart_idx", 64'(i0), 64'd0);
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (tx0 && n < 60);
    chk("restart_addr", 64'(a0), 64'd12);
    v = '0;
    for (int b = 0; b < 8; b++) begin
      @(posedge clk); #1;
      v[b] = tx0;
    end
    chk("restart_byte", 64'(v), 64'h0C);
    r0 = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_burst.md
Name: uart_tx_burst

Overview:
- Parametrised successor of the team's RS-485 burst UART transmitter.
- On a level request, asserts RS-485 direction lines, reads BYTES words from an external synchronous memory page selected by `cycle`, and serialises them on `tx`.
- Then releases the bus and flags completion.
- Adds configurable data width, baud divider, parity, stop bits, inter-frame gap and direction timing; every output has a defined reset value.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
CLKS_PER_BIT, 1, clk cycles per bit time (>=1)
BYTES, 4, frames per burst (1..255)
ADDR_W, 9, memory address width
PARITY, 0, 0=none, 1=even, 2=odd
STOP_BITS, 1, stop bits (1 or 2)
GAP_BITS, 1, idle-high bit times after stop bits, before next start bit (>=1)
DIR_ON_DLY, 15, clocks from dirRX rise to dirTX rise
TX_LEAD, 15, clocks from dirTX rise to first start bit
DIR_OFF_DLY, 4, clocks from dirTX fall to dirRX fall

Ports:
clk  in  1  bit/system clock
reset  in  1  asynchronous active-low reset
RQ  in  1  transfer request, level, asynchronous domain
cycle  in  6  memory page index
data  in  DATA_BITS  memory read data (one-clock read latency)
addr  out  ADDR_W  memory address = cycle*BYTES + idx, truncated to ADDR_W
tx  out  1  serial line, idle high
dirTX  out  1  RS-485 driver enable
dirRX  out  1  RS-485 receiver disable
full  out  1  burst complete, held until RQ released
busy  out  1  high from leaving IDLE until entering DONE
idx  out  8  current frame index (0..BYTES)

Behaviour:
- Reset (async, active low): state=IDLE; tx=1; dirTX=0; dirRX=0; full=0; busy=0; idx=0; RQ synchroniser cleared; all counters 0. Reset mid-burst aborts immediately to these values.
- RQ passes through a 2-FF synchroniser (rq_s); 2-clock latency from RQ edge to FSM.
- IDLE: on rq_s=1, go to DIRON and set busy=1, idx=0.
- DIRON:
  - dirRX=1 on first clock.
  - dirTX=1 after DIR_ON_DLY clocks.
  - START after a further TX_LEAD clocks.
- START: tx=0 for one bit time; shift register loads `data` on the first clock of the start bit.
- DATA: DATA_BITS bit times, LSB first.
- PAR (only if PARITY!=0): one bit time.
  - Even: XOR of the data bits.
  - Odd: inverse of that XOR.
- STOP: tx=1 for STOP_BITS bit times; idx increments on the first clock of STOP.
- GAP: tx=1 for GAP_BITS bit times.
  - Then if idx==BYTES go to DIROFF, else go to START.
  - `addr` therefore settles at least GAP_BITS*CLKS_PER_BIT+1 clocks before the next load, which covers the memory's one-clock latency.
- DIROFF:
  - dirTX=0 on first clock.
  - dirRX=0 after DIR_OFF_DLY clocks; on that same clock go to DONE, full=1, busy=0.
- DONE: hold full=1; on rq_s=0 clear full and go to IDLE.
- RQ falling during a burst does not abort it; the burst completes, and DONE then exits on the next clock.
- RQ held high through DONE never retriggers; a new burst requires RQ low then high.
- Bit timing:
  - A bit counter counts 0..CLKS_PER_BIT-1.
  - The state/bit index advances only on counter wrap.
  - With CLKS_PER_BIT=1, every bit is exactly one clock.
- Frame length in bit times = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS + GAP_BITS.
- addr arithmetic: computed at full width before truncation; cycle*BYTES wraps modulo 2^ADDR_W with no error flag. `cycle` is sampled once, on IDLE->DIRON, and held for the burst.
- tx is registered; no combinational path from data to tx.

Test Plan:
- Defaults, CLKS_PER_BIT=1, memory[addr]=addr[7:0], RQ=1 with cycle=3:
  - addr sequence is 12,13,14,15.
  - tx shows frames 0 0x0C..0x0F 1 1, each 11 clocks (start, 8 data, 1 stop, 1 gap).
  - dirRX rises 2 clocks after RQ; dirTX rises 15 clocks later; first start bit follows 15 clocks after that.
  - full=1 and busy=0 exactly 4 clocks after dirTX falls.
- PARITY=1, DATA_BITS=7, STOP_BITS=2, CLKS_PER_BIT=4, data=0x55 -> parity bit 0, each bit held 4 clocks; frame = 4*(1+7+1+2+1) = 48 clocks.
- PARITY=2, data=0x01 -> parity bit 0; with data=0x03 -> parity bit 1.
- RQ dropped mid-burst -> all BYTES frames still sent; full pulses 1 clock in DONE then returns to IDLE; RQ held high after DONE -> no second burst until RQ toggles low then high.
- reset asserted mid-DATA -> same clock: tx=1, dirTX=0, dirRX=0, busy=0; after release with RQ still high, a fresh burst starts from idx=0.
- BYTES=1, cycle=63, ADDR_W=6 -> addr = 63 mod 64 = 63; single frame, then DIROFF.
